graph_palette: RTL and testbench
================================

// Module: graph_palette
// PURPOSE
//  Programmable, pipelined instrument colour palette for the note-graph renderer.
//  Maps an instrument index plus a brightness level to a scaled RGB colour.
//  Sits between the graph pixel generator (requester) and the VGA pixel mux.
//  Palette entries are rewritable at run time.
// PARAMETERS
//  N_INST  8   number of palette entries (instruments), >=2
//  IDX_W   $clog2(N_INST)  index width (derived, do not override)
//  CW      8   bits per colour channel; the colour word is 3*CW bits {R,G,B}
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  wr_en      in   1       palette write strobe
//  wr_idx     in   IDX_W   entry to write
//  wr_color   in   3*CW    new {R,G,B} for wr_idx
//  rd_valid   in   1       lookup request valid
//  rd_inst    in   IDX_W   instrument to look up
//  rd_level   in   8       brightness, 0=black, 255=full
//  frame_tick in   1       one-cycle pulse per video frame (glow decay)
//  hit_valid  in   1       note-on strobe (glow trigger)
//  hit_inst   in   IDX_W   instrument that was struck
//  color_valid out 1       output colour valid
//  color      out  3*CW    scaled {R,G,B}
// BEHAVIOUR
//  - One clock, async active-high reset; single cycle per request, no back-pressure
//    (a new request may be accepted every cycle).
//  - Reset: color_valid=0, color=0, glow counters=0, palette reloaded with defaults:
//    idx%8: 0 FFCF70, 1 77FF70, 2 F44141, 3 4286F4, 4 B241F4, 5 F49741, 6 41F4F4, 7 09BA00.
//    Each 8-bit default channel c8 maps to CW bits as c8<<(CW-8) if CW>=8, else c8>>(8-CW).
//  - Reset asserted mid-stream flushes both pipeline stages; in-flight requests and
//    runtime writes are lost.
//  - Stage 1 (cycle t+1): register palette[rd_inst], effective level, and rd_valid.
//  - Stage 2 (cycle t+2): per channel out = (c * (lvl+1)) >> 8, product width CW+9,
//    truncated to CW; color_valid = stage-1 valid. Latency is exactly 2 cycles.
//  - When color_valid=0, color holds its previous value (not forced to 0).
//  - lvl=255 returns the entry unchanged; lvl=0 returns 0.
//  - Write: entry updates at the clock edge where wr_en=1. A read of the same index
//    in the same cycle returns the OLD value (read-before-write).
//  - rd_inst/wr_idx/hit_inst >= N_INST (non-power-of-2 N_INST): a read returns
//    entry 0; writes and hits are ignored.
// CONFIGURATION
//  GRAPH_PALETTE_GLOW_EN defined:
//   - per-entry 4-bit glow counter; hit_valid loads glow[hit_inst]=15.
//   - frame_tick decrements every non-zero counter by 1 (saturates at 0).
//   - hit and tick on the same entry in the same cycle: the load wins (15).
//   - effective level = min(255, rd_level + 8*glow[rd_inst]), sampled in stage 1.
//  Not defined: hit_valid/hit_inst/frame_tick are ignored, no glow storage is built,
//   effective level = rd_level. Ports remain present in both builds.
// TESTING
//  1 reset, rd inst=3 lvl=255 -> 2 cycles later color_valid=1, color=4286F4.
//  2 rd inst=0 lvl=127 -> color=7F6738 (FF*128>>8=7F, CF->67, 70->38); lvl=0 -> 000000.
//  3 wr idx=2 color=123456 with rd inst=2 lvl=255 in the same cycle -> F44141;
//    repeat the read next cycle -> 123456.
//  4 back-to-back rd inst=0..7 lvl=255 on 8 consecutive cycles -> 8 consecutive valid
//    defaults in order; assert reset mid-burst -> color_valid=0 immediately, entry 2
//    reads F44141 again.
//  5 GLOW_EN: hit inst=1, rd inst=1 lvl=200 -> lvl 255 -> 77FF70; after 3 frame_ticks
//    (glow=12) lvl=255 still; after 15 ticks lvl=200 -> 5DC857.
//  6 no GLOW_EN: same hit stimulus -> rd inst=1 lvl=200 gives 5DC857 at once.

Source files
------------

// File: rtl/graph_palette_if.sv
// Request/write/glow/colour bundle between the note-graph pixel generator and graph_palette.
// The master drives requests and palette writes; the slave returns the scaled colour.
interface graph_palette_if #(
    parameter int N_INST = 8,
    parameter int CW     = 8
);
    localparam int IDX_W = (N_INST > 1) ? $clog2(N_INST) : 1;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3*CW-1:0]   wr_color;
    logic              rd_valid;
    logic [IDX_W-1:0]  rd_inst;
    logic [7:0]        rd_level;
    logic              frame_tick;
    logic              hit_valid;
    logic [IDX_W-1:0]  hit_inst;
    logic              color_valid;
    logic [3*CW-1:0]   color;

    modport master (
        output wr_en, wr_idx, wr_color,
        output rd_valid, rd_inst, rd_level,
        output frame_tick, hit_valid, hit_inst,
        input  color_valid, color
    );

    modport slave (
        input  wr_en, wr_idx, wr_color,
        input  rd_valid, rd_inst, rd_level,
        input  frame_tick, hit_valid, hit_inst,
        output color_valid, color
    );
endinterface

// File: rtl/graph_palette.sv
// Two-stage programmable instrument palette: lookup + brightness scaling, 2-cycle latency.
// Define GRAPH_PALETTE_GLOW_EN to build the per-instrument note-on glow that boosts brightness.
module graph_palette #(
    parameter int N_INST = 8,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    graph_palette_if.slave bus
);
    localparam int IDX_W = (N_INST > 1) ? $clog2(N_INST) : 1;
    localparam logic [IDX_W:0] N_INST_W = (IDX_W + 1)'(N_INST);

    function automatic logic [CW-1:0] scale_c8(input logic [7:0] c8);
        logic [CW+7:0] w;
        w = {{CW{1'b0}}, c8};
        if (CW >= 8) w = w << (CW - 8);
        else         w = w >> (8 - CW);
        return w[CW-1:0];
    endfunction

    function automatic logic [3*CW-1:0] default_color(input int idx);
        logic [23:0]     c8;
        logic [3*CW-1:0] res;
        case (idx % 8)
            0:       c8 = 24'hFFCF70;
            1:       c8 = 24'h77FF70;
            2:       c8 = 24'hF44141;
            3:       c8 = 24'h4286F4;
            4:       c8 = 24'hB241F4;
            5:       c8 = 24'hF49741;
            6:       c8 = 24'h41F4F4;
            default: c8 = 24'h09BA00;
        endcase
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            res[ch*CW +: CW] = scale_c8(c8[ch*8 +: 8]);
        end
        return res;
    endfunction

    logic [3*CW-1:0]  r_palette [N_INST];
    logic [N_INST-1:0] w_wr_sel;
    logic [IDX_W-1:0] w_rd_sel;
    logic [7:0]       w_lvl_eff;

    logic             r_s1_valid;
    logic [3*CW-1:0]  r_s1_color;
    logic [7:0]       r_s1_level;
    logic [8:0]       w_lvl_p1;
    logic [3*CW-1:0]  w_scaled;
    logic             r_color_valid;
    logic [3*CW-1:0]  r_color;

    // Out-of-range indices never match an entry, so such writes fall through.
    generate
        for (genvar gi = 0; gi < N_INST; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = bus.wr_en && (bus.wr_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        for (int i = 0; i < N_INST; i++) begin
            if (reset) begin
                r_palette[i] <= default_color(i);
            end else if (w_wr_sel[i]) begin
                r_palette[i] <= bus.wr_color;
            end
        end
    end

    assign w_rd_sel = ({1'b0, bus.rd_inst} < N_INST_W) ? bus.rd_inst : '0;

`ifdef GRAPH_PALETTE_GLOW_EN
    logic [3:0]        r_glow [N_INST];
    logic [N_INST-1:0] w_hit_sel;
    logic [8:0]        w_lvl_sum;

    generate
        for (genvar gi = 0; gi < N_INST; gi++) begin : g_hit_sel
            assign w_hit_sel[gi] = bus.hit_valid && (bus.hit_inst == IDX_W'(gi));
        end
    endgenerate

    // A note-on reload takes priority over the frame decay of the same entry.
    always_ff @(posedge clk or posedge reset) begin
        for (int i = 0; i < N_INST; i++) begin
            if (reset) begin
                r_glow[i] <= 4'd0;
            end else if (w_hit_sel[i]) begin
                r_glow[i] <= 4'hF;
            end else if (bus.frame_tick && (r_glow[i] != 4'd0)) begin
                r_glow[i] <= r_glow[i] - 4'd1;
            end
        end
    end

    assign w_lvl_sum = {1'b0, bus.rd_level} + {2'b00, r_glow[w_rd_sel], 3'b000};
    assign w_lvl_eff = w_lvl_sum[8] ? 8'hFF : w_lvl_sum[7:0];
`else
    logic w_unused_glow;
    assign w_unused_glow = &{1'b0, bus.hit_valid, bus.hit_inst, bus.frame_tick};
    assign w_lvl_eff     = bus.rd_level;
`endif

    // Scaling by (lvl+1)/256 makes 255 an exact identity and 0 black.
    assign w_lvl_p1 = {1'b0, r_s1_level} + 9'd1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [CW+8:0] w_prod;
            assign w_prod = {9'd0, r_s1_color[gi*CW +: CW]} * {{CW{1'b0}}, w_lvl_p1};
            assign w_scaled[gi*CW +: CW] = CW'(w_prod >> 8);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_color    <= '0;
            r_s1_level    <= '0;
            r_color_valid <= 1'b0;
            r_color       <= '0;
        end else begin
            r_s1_valid <= bus.rd_valid;
            if (bus.rd_valid) begin
                r_s1_color <= r_palette[w_rd_sel];
                r_s1_level <= w_lvl_eff;
            end
            r_color_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_color <= w_scaled;
            end
        end
    end

    assign bus.color_valid = r_color_valid;
    assign bus.color       = r_color;
endmodule

// File: tb/tb_graph_palette.sv
// Self-checking bench for graph_palette: directed table, corner sequences and random traffic
// compared against a cycle-level behavioural model of the palette.
module tb_graph_palette;
    localparam int NI = 8;

    logic clk;
    logic reset;

    graph_palette_if #(.N_INST(NI), .CW(8)) bus ();

    graph_palette #(.N_INST(NI), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] dflt [NI] = '{24'hFFCF70, 24'h77FF70, 24'hF44141, 24'h4286F4,
                               24'hB241F4, 24'hF49741, 24'h41F4F4, 24'h09BA00};

    // Behavioural model state
    logic [23:0] m_pal  [NI];
    int          m_glow [NI];
    logic        m_s1_valid;
    logic [23:0] m_s1_color;
    logic        m_out_valid;
    logic [23:0] m_out_color;

    typedef struct {
        logic [2:0]  inst;
        logic [7:0]  level;
        logic [23:0] exp_color;
    } vec_t;

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
        logic [23:0] r;
        int v;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(c[ch*8 +: 8]);
            r[ch*8 +: 8] = 8'((v * (lvl + 1)) / 256);
        end
        return r;
    endfunction

    function automatic logic [23:0] m_lookup(input int inst, input int level);
        int idx;
        int lvl;
        idx = (inst < NI) ? inst : 0;
        lvl = level;
`ifdef GRAPH_PALETTE_GLOW_EN
        lvl = lvl + 8 * m_glow[idx];
        if (lvl > 255) lvl = 255;
`endif
        return scale(m_pal[idx], lvl);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pal[i]  = dflt[i];
            m_glow[i] = 0;
        end
        m_s1_valid  = 1'b0;
        m_s1_color  = '0;
        m_out_valid = 1'b0;
        m_out_color = '0;
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.wr_idx     = '0;
        bus.wr_color   = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_inst    = '0;
        bus.rd_level   = '0;
        bus.frame_tick = 1'b0;
        bus.hit_valid  = 1'b0;
        bus.hit_inst   = '0;
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare.
    task automatic step();
        @(posedge clk);
        m_out_valid = m_s1_valid;
        if (m_s1_valid) m_out_color = m_s1_color;
        m_s1_valid = bus.rd_valid;
        if (bus.rd_valid) m_s1_color = m_lookup(int'(bus.rd_inst), int'(bus.rd_level));
        if (bus.wr_en && int'(bus.wr_idx) < NI) m_pal[bus.wr_idx] = bus.wr_color;
`ifdef GRAPH_PALETTE_GLOW_EN
        if (bus.frame_tick)
            for (int i = 0; i < NI; i++) if (m_glow[i] > 0) m_glow[i]--;
        if (bus.hit_valid && int'(bus.hit_inst) < NI) m_glow[bus.hit_inst] = 15;
`endif
        #1;
        chk("model_valid", {23'd0, bus.color_valid}, {23'd0, m_out_valid});
        chk("model_color", bus.color, m_out_color);
    endtask

    task automatic read_req(input int inst, input int level);
        bus.rd_valid = 1'b1;
        bus.rd_inst  = 3'(inst);
        bus.rd_level = 8'(level);
    endtask

    // Async reset pulse between edges; the output must clear without waiting for a clock.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_flush_valid", {23'd0, bus.color_valid}, 24'd0);
        chk("rst_flush_color", bus.color, 24'd0);
        model_reset();
        idle_inputs();
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{3'd3, 8'd255, 24'h4286F4};
        vecs[1] = '{3'd0, 8'd127, 24'h7F6738};
        vecs[2] = '{3'd0, 8'd0,   24'h000000};
        vecs[3] = '{3'd7, 8'd255, 24'h09BA00};
        vecs[4] = '{3'd5, 8'd128, 24'h7A4C20};
        vecs[5] = '{3'd1, 8'd200, 24'h5DC857};
        vecs[6] = '{3'd6, 8'd1,   24'h000101};

        reset = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {23'd0, bus.color_valid}, 24'd0);
        chk("reset_color", bus.color, 24'd0);
        #2;
        reset = 1'b0;

        // Directed table: one request, then an idle cycle so the result lands.
        for (int i = 0; i < 7; i++) begin
            read_req(int'(vecs[i].inst), int'(vecs[i].level));
            step();
            idle_inputs();
            step();
            chk("vec_color", bus.color, vecs[i].exp_color);
            chk("vec_valid", {23'd0, bus.color_valid}, 24'd1);
            $display("vec %0d inst=%0d lvl=%0d color=%h", i, vecs[i].inst, vecs[i].level, bus.color);
        end

        // Held output after the valid pulse drops.
        step();
        chk("hold_color", bus.color, 24'h000101);

        // Back-to-back burst of all defaults at full brightness.
        for (int i = 0; i < NI; i++) begin
            read_req(i, 255);
            step();
            if (i >= 1) chk("burst_color", bus.color, dflt[i-1]);
        end
        idle_inputs();
        step();
        chk("burst_last", bus.color, dflt[NI-1]);

        // Read-before-write on the same entry in the same cycle.
        bus.wr_en    = 1'b1;
        bus.wr_idx   = 3'd2;
        bus.wr_color = 24'h123456;
        read_req(2, 255);
        step();
        bus.wr_en = 1'b0;
        step();
        chk("rbw_old", bus.color, 24'hF44141);
        idle_inputs();
        step();
        chk("rbw_new", bus.color, 24'h123456);

        // Burst interrupted by reset: pipeline flushed, runtime write lost.
        for (int i = 0; i < NI; i++) begin
            read_req(i, 255);
            step();
            if (i == 4) begin
                mid_reset();
                break;
            end
        end
        read_req(2, 255);
        step();
        idle_inputs();
        step();
        chk("rst_default_back", bus.color, 24'hF44141);

        // Glow: strike, then decay over frame ticks.
        bus.hit_valid = 1'b1;
        bus.hit_inst  = 3'd1;
        step();
        idle_inputs();
        read_req(1, 200);
        step();
        idle_inputs();
        step();
`ifdef GRAPH_PALETTE_GLOW_EN
        chk("glow_hit", bus.color, 24'h77FF70);
`else
        chk("glow_hit", bus.color, 24'h5DC857);
`endif
        bus.frame_tick = 1'b1;
        repeat (3) step();
        idle_inputs();
        read_req(1, 200);
        step();
        idle_inputs();
        step();
`ifdef GRAPH_PALETTE_GLOW_EN
        chk("glow_tick3", bus.color, 24'h77FF70);
`else
        chk("glow_tick3", bus.color, 24'h5DC857);
`endif
        bus.frame_tick = 1'b1;
        repeat (12) step();
        idle_inputs();
        read_req(1, 200);
        step();
        idle_inputs();
        step();
        chk("glow_decayed", bus.color, 24'h5DC857);

        // Hit and tick on the same entry together: the reload wins.
        bus.hit_valid  = 1'b1;
        bus.hit_inst   = 3'd4;
        bus.frame_tick = 1'b1;
        step();
        idle_inputs();
        read_req(4, 0);
        step();
        idle_inputs();
        step();
`ifdef GRAPH_PALETTE_GLOW_EN
        chk("glow_hit_tick", bus.color, 24'h541E73);
`else
        chk("glow_hit_tick", bus.color, 24'h000000);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int lv;
            lv = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) lv = 255;
            if ($urandom_range(0, 7) == 0) lv = 0;
            bus.rd_valid   = ($urandom_range(0, 3) != 0);
            bus.rd_inst    = 3'($urandom_range(0, NI - 1));
            bus.rd_level   = 8'(lv);
            bus.wr_en      = ($urandom_range(0, 7) == 0);
            bus.wr_idx     = 3'($urandom_range(0, NI - 1));
            bus.wr_color   = 24'($urandom);
            bus.hit_valid  = ($urandom_range(0, 5) == 0);
            bus.hit_inst   = 3'($urandom_range(0, NI - 1));
            bus.frame_tick = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_inputs();
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
